// File: rtl/ps2_key_event_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_rx
// Purpose  : PS/2 keyboard receiver. Conditions the asynchronous PS/2 lines,
//            deframes 11-bit frames (start, 8 data LSB first, odd parity,
//            stop), folds E0 (extended) and F0 (break) prefixes into single
//            key events and queues them in a first-word-fall-through FIFO.
// Ports    : CLK_50M, RST        - system clock, synchronous active-high reset
//            PS2_CLK, PS2_DATA   - asynchronous PS/2 bus lines
//            i_evt_ready         - consumer accepts the head event
//            i_clr               - clears sticky o_overflow
//            o_evt_valid         - FIFO not empty
//            o_evt_code/ext/brk  - head event {scan code, E0 seen, F0 seen}
//            o_fifo_level        - entries held
//            o_overflow          - sticky: event dropped on a full FIFO
//            o_frame_err         - one-cycle pulse per discarded frame
// Options  : PS2_TYPEMATIC_FILTER_EN - suppress auto-repeat makes of the
//            currently held key
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_rx #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_US  = 2000
) (
    input  logic                          CLK_50M,
    input  logic                          RST,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    input  logic                          i_evt_ready,
    input  logic                          i_clr,
    output logic                          o_evt_valid,
    output logic [7:0]                    o_evt_code,
    output logic                          o_evt_ext,
    output logic                          o_evt_brk,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic                          o_frame_err
);

    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_LW     = c_AW + 1;
    localparam int c_FW     = $clog2(FILTER_LEN);
    localparam int c_TO_CYC = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int c_TW     = $clog2(c_TO_CYC + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = PS2_CLK, bit 1 = PS2_DATA
    // ------------------------------------------------------------------
    logic [1:0] w_pins;
    logic [1:0] w_filt;
    assign w_pins = {PS2_DATA, PS2_CLK};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic            r_s1_q, w_s1_d;
            logic            r_s2_q, w_s2_d;
            logic            r_filt_q, w_filt_d;
            logic [c_FW-1:0] r_cnt_q, w_cnt_d;

            // The filtered level flips on the FILTER_LEN-th consecutive
            // differing sample; any agreeing sample restarts the count.
            always_comb begin
                w_s1_d   = w_pins[gi];
                w_s2_d   = r_s1_q;
                w_filt_d = r_filt_q;
                w_cnt_d  = '0;
                if (r_s2_q != r_filt_q) begin
                    if (r_cnt_q == c_FW'(FILTER_LEN - 1)) begin
                        w_filt_d = r_s2_q;
                    end else begin
                        w_cnt_d = r_cnt_q + c_FW'(1);
                    end
                end
            end

            always_ff @(posedge CLK_50M) begin
                if (RST) begin
                    r_s1_q   <= 1'b1;
                    r_s2_q   <= 1'b1;
                    r_filt_q <= 1'b1;
                    r_cnt_q  <= '0;
                end else begin
                    r_s1_q   <= w_s1_d;
                    r_s2_q   <= w_s2_d;
                    r_filt_q <= w_filt_d;
                    r_cnt_q  <= w_cnt_d;
                end
            end

            assign w_filt[gi] = r_filt_q;
        end
    endgenerate

    logic r_fclk_prev_q, w_fclk_prev_d;
    logic w_fall_stb;
    logic w_dat;

    assign w_fclk_prev_d = w_filt[0];
    assign w_fall_stb    = r_fclk_prev_q & ~w_filt[0];
    assign w_dat         = w_filt[1];

    // ------------------------------------------------------------------
    // Frame FSM and inter-edge timeout
    // ------------------------------------------------------------------
    logic [1:0]      r_state_q, w_state_d;
    logic [2:0]      r_bit_cnt_q, w_bit_cnt_d;
    logic [7:0]      r_shift_q, w_shift_d;
    logic            r_parity_q, w_parity_d;
    logic            r_byte_stb_q, w_byte_stb_d;
    logic            r_frame_err_q, w_frame_err_d;
    logic [c_TW-1:0] r_to_cnt_q, w_to_cnt_d;

    always_comb begin
        w_state_d     = r_state_q;
        w_bit_cnt_d   = r_bit_cnt_q;
        w_shift_d     = r_shift_q;
        w_parity_d    = r_parity_q;
        w_byte_stb_d  = 1'b0;
        w_frame_err_d = 1'b0;

        if ((r_state_q == c_ST_IDLE) || w_fall_stb) begin
            w_to_cnt_d = '0;
        end else begin
            w_to_cnt_d = r_to_cnt_q + c_TW'(1);
        end

        if (w_fall_stb) begin
            case (r_state_q)
                c_ST_IDLE: begin
                    // A high data line on a falling edge is not a start bit.
                    if (!w_dat) begin
                        w_state_d   = c_ST_DATA;
                        w_bit_cnt_d = 3'd0;
                    end
                end
                c_ST_DATA: begin
                    w_shift_d = {w_dat, r_shift_q[7:1]};
                    if (r_bit_cnt_q == 3'd7) begin
                        w_state_d = c_ST_PARITY;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt_q + 3'd1;
                    end
                end
                c_ST_PARITY: begin
                    w_parity_d = w_dat;
                    w_state_d  = c_ST_STOP;
                end
                default: begin
                    if ((^{r_shift_q, r_parity_q}) && w_dat) begin
                        w_byte_stb_d = 1'b1;
                    end else begin
                        w_frame_err_d = 1'b1;
                    end
                    w_state_d = c_ST_IDLE;
                end
            endcase
        end else if ((r_state_q != c_ST_IDLE) &&
                     (r_to_cnt_q == c_TW'(c_TO_CYC - 1))) begin
            w_frame_err_d = 1'b1;
            w_state_d     = c_ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder (acts on the registered byte strobe / error pulse)
    // ------------------------------------------------------------------
    logic       r_ext_q, w_ext_d;
    logic       r_brk_q, w_brk_d;
    logic       w_push;
    logic [9:0] w_push_data;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       r_held_vld_q, w_held_vld_d;
    logic [8:0] r_held_q, w_held_d;
`endif

    always_comb begin
        w_ext_d     = r_ext_q;
        w_brk_d     = r_brk_q;
        w_push      = 1'b0;
        w_push_data = {r_ext_q, r_brk_q, r_shift_q};
`ifdef PS2_TYPEMATIC_FILTER_EN
        w_held_vld_d = r_held_vld_q;
        w_held_d     = r_held_q;
`endif
        if (r_frame_err_q) begin
            w_ext_d = 1'b0;
            w_brk_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            w_held_vld_d = 1'b0;
`endif
        end else if (r_byte_stb_q) begin
            if (r_shift_q == 8'hE0) begin
                w_ext_d = 1'b1;
            end else if (r_shift_q == 8'hF0) begin
                w_brk_d = 1'b1;
            end else begin
                w_push  = 1'b1;
                w_ext_d = 1'b0;
                w_brk_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (!r_brk_q) begin
                    // Repeated make of the key already down: swallow it.
                    if (r_held_vld_q && (r_held_q == {r_ext_q, r_shift_q})) begin
                        w_push = 1'b0;
                    end else begin
                        w_held_vld_d = 1'b1;
                        w_held_d     = {r_ext_q, r_shift_q};
                    end
                end else if (r_held_vld_q && (r_held_q == {r_ext_q, r_shift_q})) begin
                    w_held_vld_d = 1'b0;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT event FIFO
    // ------------------------------------------------------------------
    logic [9:0]      r_mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_LW-1:0] r_level_q, w_level_d;
    logic            r_ovf_q, w_ovf_d;
    logic            w_empty, w_full, w_pop, w_wr_en, w_drop;
    logic [9:0]      w_head;

    assign w_empty = (r_level_q == '0);
    assign w_full  = (r_level_q == c_LW'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & i_evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;
    assign w_head  = r_mem_q[r_rd_ptr_q];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_wr_en) begin
            w_wr_ptr_d = r_wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_AW'(1);
        end
        case ({w_wr_en, w_pop})
            2'b10:   w_level_d = r_level_q + c_LW'(1);
            2'b01:   w_level_d = r_level_q - c_LW'(1);
            default: w_level_d = r_level_q;
        endcase
        // Set has priority over clear.
        if (w_drop) begin
            w_ovf_d = 1'b1;
        end else if (i_clr) begin
            w_ovf_d = 1'b0;
        end else begin
            w_ovf_d = r_ovf_q;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (w_wr_en) begin
            r_mem_q[r_wr_ptr_q] <= w_push_data;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_fclk_prev_q <= 1'b1;
            r_state_q     <= c_ST_IDLE;
            r_bit_cnt_q   <= 3'd0;
            r_shift_q     <= 8'h00;
            r_parity_q    <= 1'b0;
            r_byte_stb_q  <= 1'b0;
            r_frame_err_q <= 1'b0;
            r_to_cnt_q    <= '0;
            r_ext_q       <= 1'b0;
            r_brk_q       <= 1'b0;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_level_q     <= '0;
            r_ovf_q       <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            r_held_vld_q  <= 1'b0;
            r_held_q      <= 9'h000;
`endif
        end else begin
            r_fclk_prev_q <= w_fclk_prev_d;
            r_state_q     <= w_state_d;
            r_bit_cnt_q   <= w_bit_cnt_d;
            r_shift_q     <= w_shift_d;
            r_parity_q    <= w_parity_d;
            r_byte_stb_q  <= w_byte_stb_d;
            r_frame_err_q <= w_frame_err_d;
            r_to_cnt_q    <= w_to_cnt_d;
            r_ext_q       <= w_ext_d;
            r_brk_q       <= w_brk_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_level_q     <= w_level_d;
            r_ovf_q       <= w_ovf_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
            r_held_vld_q  <= w_held_vld_d;
            r_held_q      <= w_held_d;
`endif
        end
    end

    // Head outputs read as zero while empty so nothing undefined escapes.
    assign o_evt_valid  = ~w_empty;
    assign o_evt_code   = w_empty ? 8'h00 : w_head[7:0];
    assign o_evt_brk    = w_empty ? 1'b0  : w_head[8];
    assign o_evt_ext    = w_empty ? 1'b0  : w_head[9];
    assign o_fifo_level = r_level_q;
    assign o_overflow   = r_ovf_q;
    assign o_frame_err  = r_frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_event_rx
// Purpose  : Self-checking bench for ps2_key_event_rx. Drives PS/2 frames
//            bit by bit and compares events against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_rx;

    localparam int c_FILTER = 8;
    localparam int c_TO_CYC = 500;      // 10 MHz * 50 us
    localparam int c_HALF   = 20;       // PS/2 half bit period in clocks
    localparam int c_LAT    = 2 + c_FILTER + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_data, evt_ready, clr;
    logic       evt_valid, evt_ext, evt_brk, overflow, frame_err;
    logic [7:0] evt_code;
    logic [3:0] fifo_level;

    ps2_key_event_rx #(
        .CLK_FREQ_HZ (10000000),
        .FILTER_LEN  (c_FILTER),
        .FIFO_DEPTH  (8),
        .TIMEOUT_US  (50)
    ) u_dut (
        .CLK_50M      (clk),
        .RST          (rst),
        .PS2_CLK      (ps2_clk),
        .PS2_DATA     (ps2_data),
        .i_evt_ready  (evt_ready),
        .i_clr        (clr),
        .o_evt_valid  (evt_valid),
        .o_evt_code   (evt_code),
        .o_evt_ext    (evt_ext),
        .o_evt_brk    (evt_brk),
        .o_fifo_level (fifo_level),
        .o_overflow   (overflow),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int err_cnt = 0;
    int last_err_cyc = 0;
    int rise_cyc = 0;
    int vfall_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) begin
            err_cnt      = err_cnt + 1;
            last_err_cyc = cyc;
        end
        if (evt_valid && !prev_valid) rise_cyc = cyc;
        if (!evt_valid && prev_valid) vfall_cyc = cyc;
        prev_valid = evt_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        idle(c_HALF);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        idle(c_HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d) ^ par_flip);
        send_bit(1'b1);
        idle(30);
    endtask

    task automatic pop_one();
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       exp_evt;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       exp_err;
    } vec_t;

    vec_t tbl[12];
    logic [8:0] tm_exp[5];
    int tm_n;
    int e0;
    int waited;

    initial begin
        tbl[0]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{8'h32, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{8'h32, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{8'hE1, 1'b0, 1'b1, 8'hE1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0};

`ifdef PS2_TYPEMATIC_FILTER_EN
        tm_n = 3;
        tm_exp[0] = {1'b0, 8'h1C};
        tm_exp[1] = {1'b1, 8'h1C};
        tm_exp[2] = {1'b0, 8'h1C};
        tm_exp[3] = 9'h000;
        tm_exp[4] = 9'h000;
`else
        tm_n = 5;
        tm_exp[0] = {1'b0, 8'h1C};
        tm_exp[1] = {1'b0, 8'h1C};
        tm_exp[2] = {1'b0, 8'h1C};
        tm_exp[3] = {1'b1, 8'h1C};
        tm_exp[4] = {1'b0, 8'h1C};
`endif

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0; clr = 1'b0;
        idle(5);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_code",  32'(evt_code), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_err",   32'(frame_err), 32'd0);
        rst = 1'b0;
        idle(20);

        // Latency / single-cycle pulse with the consumer always ready
        evt_ready = 1'b1;
        send_frame(8'h1C, 1'b0);
        check("lat_rise",  32'(rise_cyc - last_fall_cyc), 32'(c_LAT));
        check("lat_width", 32'(vfall_cyc - rise_cyc), 32'd1);
        check("lat_level", 32'(fifo_level), 32'd0);
        evt_ready = 1'b0;

        // Table of single frames, consumer held off, one event inspected each
        for (int i = 0; i < 12; i++) begin
            e0 = err_cnt;
            send_frame(tbl[i].data, tbl[i].par_flip);
            check($sformatf("tbl%0d_err", i), 32'(err_cnt - e0), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_valid", i), 32'(evt_valid), 32'(tbl[i].exp_evt));
            if (tbl[i].exp_evt) begin
                check($sformatf("tbl%0d_event", i), {22'd0, evt_ext, evt_brk, evt_code},
                      {22'd0, tbl[i].ext, tbl[i].brk, tbl[i].code});
                pop_one();
                check($sformatf("tbl%0d_popped", i), 32'(fifo_level), 32'd0);
            end
        end

        // Overflow: nine makes into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain%0d", i), {23'd0, evt_valid, evt_code}, {23'd0, 1'b1, 8'(i)});
            evt_ready = 1'b1;
            @(negedge clk);
        end
        evt_ready = 1'b0;
        check("drain_empty", 32'(fifo_level), 32'd0);
        check("ovf_sticky",  32'(overflow), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // Timeout: start bit plus four data bits, then the clock stays high
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        waited = 0;
        while (err_cnt == e0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("to_fired", 32'(err_cnt - e0), 32'd1);
        if (err_cnt != e0) begin
            n_checks++;
            if ((last_err_cyc - last_fall_cyc) < (c_TO_CYC + c_FILTER) ||
                (last_err_cyc - last_fall_cyc) > (c_TO_CYC + c_FILTER + 6)) begin
                n_errors++;
                $display("FAIL to_time: got %0d cycles expected about %0d",
                         last_err_cyc - last_fall_cyc, c_TO_CYC + c_FILTER + 3);
            end
        end
        idle(10);
        send_frame(8'h1C, 1'b0);
        check("to_next", {23'd0, evt_valid, evt_code}, {23'd0, 1'b1, 8'h1C});
        pop_one();

        // Auto-repeat sequence after a bad frame clears any held key
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        check("tm_pre_err", 32'(err_cnt - e0), 32'd1);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("tm_level", 32'(fifo_level), 32'(tm_n));
        @(negedge clk);
        for (int i = 0; i < tm_n; i++) begin
            check($sformatf("tm_evt%0d", i), {22'd0, evt_valid, evt_brk, evt_code},
                  {22'd0, 1'b1, tm_exp[i]});
            evt_ready = 1'b1;
            @(negedge clk);
        end
        evt_ready = 1'b0;
        check("tm_empty", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
